// File: rtl/tlut_pkg.sv
// Shared T-LUT definitions: custom-0 instruction encoding, func codes and sequencer states.
// Used by the PCPI sequencer (initiator) and the T-LUT PCPI wrapper (decoder).
package tlut_pkg;

  localparam logic [6:0] OPC_CUSTOM0 = 7'h0B;
  localparam logic [2:0] FUNCT3_TLUT = 3'd0;
  localparam logic [4:0] REG_A0      = 5'd10;
  localparam logic [4:0] REG_ZERO    = 5'd0;

  localparam logic [6:0] F7_SIGMOID = 7'd0;
  localparam logic [6:0] F7_TANH    = 7'd1;
  localparam logic [6:0] F7_EXP     = 7'd2;

  localparam logic [31:0] INSN_SIGMOID = {F7_SIGMOID, REG_ZERO, REG_A0, FUNCT3_TLUT, REG_A0, OPC_CUSTOM0};
  localparam logic [31:0] INSN_TANH    = {F7_TANH,    REG_ZERO, REG_A0, FUNCT3_TLUT, REG_A0, OPC_CUSTOM0};
  localparam logic [31:0] INSN_EXP     = {F7_EXP,     REG_ZERO, REG_A0, FUNCT3_TLUT, REG_A0, OPC_CUSTOM0};

  typedef enum logic [1:0] {
    FUNC_SIGMOID = 2'd0,
    FUNC_TANH    = 2'd1,
    FUNC_EXP     = 2'd2,
    FUNC_RSVD    = 2'd3
  } tlut_func_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  function automatic logic [31:0] insn_for(input logic [1:0] f);
    logic [31:0] w;
    case (f)
      FUNC_TANH: w = INSN_TANH;
      FUNC_EXP:  w = INSN_EXP;
      default:   w = INSN_SIGMOID;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/tlut_pcpi_sequencer.sv
// Streams bytes through the T-LUT coprocessor as a PCPI initiator; 3 cycles per element plus responder wait.
// Backpressure: in_ready only in FETCH, out_valid holds out_data until out_ready; TIMEOUT idle cycles abort an issue.
module tlut_pcpi_sequencer
  import tlut_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  func,
  input  logic [7:0]  count,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  done_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_e    state_q, state_d;
  logic [7:0]    count_q, count_d;
  logic [31:0]   insn_q, insn_d;
  logic [7:0]    opnd_q, opnd_d;
  logic [7:0]    res_q, res_d;
  logic [7:0]    dcnt_q, dcnt_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          in_ready_q, pcpi_valid_q, out_valid_q, busy_q, done_q;
  logic          unused_rd_hi;

  assign unused_rd_hi = ^pcpi_rd[31:8];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    insn_d  = insn_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    dcnt_d  = dcnt_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          dcnt_d  = '0;
          count_d = count;
          if (func == FUNC_RSVD) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (count == 8'd0) begin
            state_d = ST_DONE;
          end else begin
            insn_d  = insn_for(func);
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (in_valid) begin
          opnd_d  = in_data;
          tmo_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (pcpi_ready) begin
          if (pcpi_wr) begin
            res_d   = pcpi_rd[7:0];
            state_d = ST_DRAIN;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end else if (pcpi_wait) begin
          tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          dcnt_d  = dcnt_q + 8'd1;
          state_d = (({1'b0, dcnt_q} + 9'd1) < {1'b0, count_q}) ? ST_FETCH : ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Abort wins over any same-cycle handshake: nothing captured, nothing counted.
    if (abort && state_q != ST_IDLE && state_q != ST_DONE) begin
      state_d = ST_DONE;
      opnd_d  = opnd_q;
      res_d   = res_q;
      dcnt_d  = dcnt_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      insn_q       <= '0;
      opnd_q       <= '0;
      res_q        <= '0;
      dcnt_q       <= '0;
      err_q        <= 1'b0;
      tmo_q        <= '0;
      in_ready_q   <= 1'b0;
      pcpi_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      insn_q       <= insn_d;
      opnd_q       <= opnd_d;
      res_q        <= res_d;
      dcnt_q       <= dcnt_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
      in_ready_q   <= (state_d == ST_FETCH);
      pcpi_valid_q <= (state_d == ST_ISSUE);
      out_valid_q  <= (state_d == ST_DRAIN);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_DONE);
    end
  end

  assign in_ready   = in_ready_q;
  assign pcpi_valid = pcpi_valid_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  assign done_count = dcnt_q;
  assign pcpi_insn  = insn_q;
  assign pcpi_rs1   = {24'd0, opnd_q};
  assign pcpi_rs2   = 32'd0;
  assign out_data   = res_q;

endmodule

// File: tb/tb_tlut_pcpi_sequencer.sv
// Bench for tlut_pcpi_sequencer: vector table, randomized batches, abort and reset sequences.
module tb_tlut_pcpi_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  func = 2'd0;
  logic [7:0]  count = 8'd0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr = 1'b0;
  logic [31:0] pcpi_rd = 32'd0;
  logic        pcpi_wait = 1'b0;
  logic        pcpi_ready = 1'b0;
  logic        busy, done, error;
  logic [7:0]  done_count;

  tlut_pcpi_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .func(func), .count(count), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .busy(busy), .done(done), .error(error), .done_count(done_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] insn_words [4] = '{32'h0005050B, 32'h0205050B, 32'h0405050B, 32'h0};

  // Stand-in for the coprocessor's lookup tables.
  function automatic logic [7:0] golden_lut(input logic [1:0] f, input logic [7:0] x);
    int v;
    v = (int'(x) * (2 * int'(f) + 3) + 17 * int'(f)) ^ 32'h5A;
    return v[7:0];
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Knobs set by the main sequence, consumed by the environment.
  int k_wait = 0, k_stall = 0;
  bit k_wr = 1, k_silent = 0, k_stray = 0, k_gap = 0, k_rand_sink = 0, k_noise = 0, k_abort_on_ready = 0;
  int req_seq = 0, ack_seq = 0;
  logic [1:0] req_func = 2'd0;
  logic [7:0] req_count = 8'd0;
  logic [7:0] req_ops[$], cur_ops[$];

  // Observations of the current batch.
  logic [7:0]  src_q[$];
  logic [31:0] act_insn[$], act_rs1[$], act_rs2[$];
  logic [7:0]  act_out[$];
  int b_done = 0, b_lat = 0, b_viol = 0, b_ov_seen = 0, b_vlen = 0;
  int tcount = 0, wcnt = 0, vlen = 0, stall_left = 0;
  logic prev_pv = 1'b0, prev_ov = 1'b0;
  logic [7:0]  prev_od = 8'd0;
  logic [31:0] txn_insn = '0, txn_rs1 = '0, txn_rs2 = '0;

  // Environment: samples at negedge, then drives inputs for the next rising edge.
  initial begin
    logic [31:0] rnd;
    forever begin
      @(negedge clk);
      tcount++;
      if (done) begin b_done++; b_lat = tcount; end
      if (pcpi_valid && (in_ready || out_valid)) b_viol++;
      if (in_ready && out_valid) b_viol++;
      if (out_valid && prev_ov && out_data !== prev_od) b_viol++;
      if (out_valid) b_ov_seen++;

      abort = 1'b0;
      start = 1'b0;
      if (k_noise && busy) begin
        rnd   = $urandom();
        start = rnd[0];
        func  = rnd[2:1];
        count = rnd[15:8];
      end
      if (req_seq != ack_seq) begin
        start = 1'b1;
        func  = req_func;
        count = req_count;
        src_q = req_ops;
        act_insn.delete(); act_rs1.delete(); act_rs2.delete(); act_out.delete();
        b_done = 0; b_lat = 0; b_viol = 0; b_ov_seen = 0; b_vlen = 0;
        tcount = 0;
        stall_left = k_stall;
        ack_seq = req_seq;
      end

      if (pcpi_valid) begin
        if (!prev_pv) begin
          act_insn.push_back(pcpi_insn); act_rs1.push_back(pcpi_rs1); act_rs2.push_back(pcpi_rs2);
          txn_insn = pcpi_insn; txn_rs1 = pcpi_rs1; txn_rs2 = pcpi_rs2;
          wcnt = 0; vlen = 0;
        end else if (pcpi_insn !== txn_insn || pcpi_rs1 !== txn_rs1 || pcpi_rs2 !== txn_rs2) begin
          b_viol++;
        end
        vlen++;
        b_vlen = vlen;
        if (k_silent) begin
          pcpi_ready = 1'b0; pcpi_wait = 1'b0;
        end else if (wcnt >= k_wait) begin
          rnd = $urandom();
          pcpi_ready = 1'b1; pcpi_wait = 1'b0; pcpi_wr = k_wr;
          pcpi_rd = {rnd[31:8], golden_lut(pcpi_insn[26:25], pcpi_rs1[7:0])};
          if (k_abort_on_ready) abort = 1'b1;
        end else begin
          pcpi_ready = 1'b0; pcpi_wait = 1'b1;
          wcnt++;
        end
      end else begin
        pcpi_wait  = 1'b0;
        pcpi_ready = k_stray && ($urandom_range(0, 2) == 0);
        pcpi_wr    = 1'b1;
        pcpi_rd    = $urandom();
      end
      prev_pv = pcpi_valid;

      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = k_rand_sink ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (out_valid && out_ready) act_out.push_back(out_data);
      prev_ov = out_valid && !out_ready;
      prev_od = out_data;

      if (src_q.size() > 0 && !(k_gap && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b1;
        in_data  = src_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom());
      end
      if (in_valid && in_ready) void'(src_q.pop_front());
    end
  end

  // Reference: every operand in order becomes one transaction with the fixed word for func,
  // successful ones yield the LUT value in order.
  task automatic run_batch(input string nm, input logic [1:0] f, input int n, input int e_err,
                           input int e_dc, input int e_txn, input int e_lat, input int e_vlen);
    int guard;
    req_func  = f;
    req_count = 8'(n);
    req_ops   = cur_ops;
    req_seq++;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((ack_seq != req_seq || b_done == 0) && guard < 2000);
    check({nm, "_finished"}, 64'(guard < 2000), 64'd1);
    repeat (3) @(negedge clk);
    check({nm, "_done_pulses"}, 64'(b_done), 64'd1);
    check({nm, "_error"}, 64'(error), 64'(e_err));
    check({nm, "_done_count"}, 64'(done_count), 64'(e_dc));
    check({nm, "_busy_after"}, 64'(busy), 64'd0);
    check({nm, "_txns"}, 64'(act_insn.size()), 64'(e_txn));
    check({nm, "_results"}, 64'(act_out.size()), 64'(e_dc));
    check({nm, "_protocol"}, 64'(b_viol), 64'd0);
    if (e_lat >= 0) check({nm, "_latency"}, 64'(b_lat), 64'(e_lat));
    if (e_vlen > 0) check({nm, "_valid_len"}, 64'(b_vlen), 64'(e_vlen));
    for (int i = 0; i < act_insn.size() && i < e_txn; i++) begin
      check($sformatf("%s_insn%0d", nm, i), 64'(act_insn[i]), 64'(insn_words[f]));
      check($sformatf("%s_rs1_%0d", nm, i), 64'(act_rs1[i]), 64'({24'd0, cur_ops[i]}));
      check($sformatf("%s_rs2_%0d", nm, i), 64'(act_rs2[i]), 64'd0);
    end
    for (int i = 0; i < act_out.size() && i < e_dc; i++)
      check($sformatf("%s_out%0d", nm, i), 64'(act_out[i]), 64'(golden_lut(f, cur_ops[i])));
  endtask

  typedef struct {
    logic [1:0] f;
    int n, wt, st;
    bit wr, sil, fx;
    int e_err, e_dc, e_txn, e_lat, e_vlen;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] f, input int n, input int wt, input int st,
                              input bit wr, input bit sil, input bit fx, input int e_err,
                              input int e_dc, input int e_txn, input int e_lat, input int e_vlen);
    vec_t v;
    v.f = f; v.n = n; v.wt = wt; v.st = st; v.wr = wr; v.sil = sil; v.fx = fx;
    v.e_err = e_err; v.e_dc = e_dc; v.e_txn = e_txn; v.e_lat = e_lat; v.e_vlen = e_vlen;
    return v;
  endfunction

  initial begin
    vec_t vt[8];
    logic [7:0] fixed_ops[3];
    int g;
    fixed_ops = '{8'h00, 8'h7F, 8'h80};

    // Latency counts cycles from the start cycle to the done cycle: 1 + 3*count + waits + stalls.
    vt[0] = mk(2'd0, 3,  2, 0, 1, 0, 1, 0, 3, 3, 16, 3);
    vt[1] = mk(2'd1, 2,  0, 5, 1, 0, 0, 0, 2, 2, 12, 1);
    vt[2] = mk(2'd2, 4,  1, 0, 1, 0, 0, 0, 4, 4, 17, 2);
    vt[3] = mk(2'd3, 5,  0, 0, 1, 0, 0, 1, 0, 0, 1,  0);
    vt[4] = mk(2'd0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 1,  0);
    vt[5] = mk(2'd1, 3,  0, 0, 0, 0, 0, 1, 0, 1, 3,  1);
    vt[6] = mk(2'd2, 2,  0, 0, 1, 1, 0, 1, 0, 1, 18, 16);
    vt[7] = mk(2'd0, 1, 40, 0, 1, 0, 0, 0, 1, 1, 44, 41);

    repeat (2) @(negedge clk);
    check("rst_flags", 64'({pcpi_valid, in_ready, out_valid, busy, done, error}), 64'd0);
    check("rst_insn", 64'(pcpi_insn), 64'd0);
    check("rst_operands", 64'({pcpi_rs1, pcpi_rs2}), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_done_count", 64'(done_count), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      k_wait = vt[i].wt; k_stall = vt[i].st; k_wr = vt[i].wr; k_silent = vt[i].sil;
      cur_ops.delete();
      for (int j = 0; j < vt[i].n; j++)
        cur_ops.push_back(vt[i].fx ? fixed_ops[j] : 8'($urandom()));
      run_batch($sformatf("vec%0d", i), vt[i].f, vt[i].n, vt[i].e_err, vt[i].e_dc,
                vt[i].e_txn, vt[i].e_lat, vt[i].e_vlen);
    end

    // Randomized batches: input gaps, random sink, stray responses, start noise while busy.
    k_wr = 1; k_silent = 0; k_stray = 1; k_gap = 1; k_rand_sink = 1; k_noise = 1;
    for (int i = 0; i < 15; i++) begin
      int n;
      logic [1:0] f;
      n = $urandom_range(1, 6);
      f = 2'($urandom_range(0, 2));
      k_wait = $urandom_range(0, 3);
      k_stall = $urandom_range(0, 2);
      cur_ops.delete();
      for (int j = 0; j < n; j++) cur_ops.push_back(8'($urandom()));
      run_batch($sformatf("rnd%0d", i), f, n, 0, n, n, -1, 0);
    end
    k_stray = 0; k_gap = 0; k_rand_sink = 0; k_noise = 0; k_stall = 0;

    // Abort in the same cycle as pcpi_ready: result dropped, DONE the following cycle.
    k_wait = 1; k_abort_on_ready = 1;
    cur_ops.delete();
    cur_ops.push_back(8'h3C); cur_ops.push_back(8'hC3);
    run_batch("abort_ready", 2'd0, 2, 0, 0, 1, 4, 2);
    check("abort_no_out_valid", 64'(b_ov_seen), 64'd0);
    k_abort_on_ready = 0;

    // Reset while a transaction is outstanding.
    k_silent = 1;
    cur_ops.delete();
    cur_ops.push_back(8'h5A);
    req_func = 2'd1; req_count = 8'd1; req_ops = cur_ops; req_seq++;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!pcpi_valid && g < 100);
    check("rstmid_reached_issue", 64'(pcpi_valid), 64'd1);
    check("rstmid_insn_before", 64'(pcpi_insn), 64'h0205050B);
    reset = 1'b1;
    #1;
    check("rstmid_flags", 64'({pcpi_valid, in_ready, out_valid, busy, done, error}), 64'd0);
    check("rstmid_insn", 64'(pcpi_insn), 64'd0);
    check("rstmid_rs1", 64'(pcpi_rs1), 64'd0);
    check("rstmid_done_count", 64'(done_count), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    k_silent = 0;
    repeat (2) @(negedge clk);
    check("rstmid_idle_after", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
